ofdm_uart_tx: RTL and testbench
===============================

OFDM_UART_TX -- requirements
Module: ofdm_uart_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 27000000, meaning clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, SHALL be at least 2).
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port finish  input  1  demodulator result-valid level, held high until clear.
REQ-006 SHALL have port success  input  1  demodulator preamble-check flag, valid while finish=1.
REQ-007 SHALL have port res  input  96  demodulated payload; byte k is res[95-8k -: 8], k=0..11.
REQ-008 SHALL have port clear  output  1  one-cycle acknowledge pulse to the demodulator.
REQ-009 SHALL have port tx  output  1  UART line, 8N1, idle high, registered.
REQ-010 SHALL have port busy  output  1  high from acknowledge until frame end or drop.
REQ-011 SHALL have port tx_done  output  1  one-cycle pulse after the last stop bit of a sent frame.

Function
REQ-012 SHALL implement states IDLE, ACK, START, DATA, STOP.
REQ-013 SHALL, in IDLE with finish=1 sampled in cycle N, latch res and success into internal buffers, drive clear=1 during cycle N+1 only, and enter ACK.
REQ-014 SHALL, in ACK, go to START with tx=0 from cycle N+2 when latched success=1, else to IDLE with tx=1 and no bytes sent (dropped frame).
REQ-015 SHALL ignore finish outside IDLE; a finish still held high on return to IDLE SHALL start a new frame normally.
REQ-016 SHALL hold each bit (start, 8 data LSB-first, stop=1) for exactly CLKS_PER_BIT cycles using a bit-period counter that reloads on every bit boundary.
REQ-017 SHALL send bytes in order k=0..11 from the latched buffer; res changes after latch SHALL NOT affect the frame.
REQ-018 SHALL go from STOP to START of the next byte with no idle gap, or to IDLE after the final byte.
REQ-019 SHALL pulse tx_done in the first IDLE cycle after the final stop bit, and deassert busy in that same cycle.
REQ-020 SHALL assert busy in ACK, START, DATA and STOP only.
REQ-021 SHALL keep a sent frame at 12 bytes x 10 bits x CLKS_PER_BIT cycles, measured from the tx falling edge to tx_done (13 bytes with REQ-027).

Reset
REQ-022 SHALL, on rst=1, immediately force tx=1, clear=0, busy=0, tx_done=0, state=IDLE, and zero all counters and buffers.
REQ-023 SHALL abort a frame when reset occurs mid-frame, with no partial byte completion.
REQ-024 SHALL start a fresh frame from byte 0 when finish is seen after reset release.

Configuration
REQ-025 SHALL use macro OFDM_UART_CHECKSUM_EN.
REQ-026 SHALL, without the macro, send exactly 12 payload bytes per frame.
REQ-027 SHALL, with the macro, append a 13th byte equal to the XOR of the 12 payload bytes, computed from the latched buffer.

Verification
REQ-028 SHALL cover this case: CLK_FREQ=16, BAUD=1, pulse rst -> tx=1, clear=0, busy=0, tx_done=0 throughout reset and after release with finish=0.
REQ-029 SHALL cover this case: finish=1, success=1, res=0x55_01_02_03_04_05_06_07_08_09_0A_55 -> clear high exactly cycle N+1, tx falls at N+2, decoded bytes 55 01 02 ... 0A 55, tx_done 1920 cycles after the tx fall.
REQ-030 SHALL cover this case: finish=1, success=0 -> clear high one cycle, busy high only in cycle N+1, tx stays 1, no tx_done.
REQ-031 SHALL cover this case: same stimulus as REQ-029 with OFDM_UART_CHECKSUM_EN defined -> 13th byte 0x0B, tx_done 2080 cycles after the tx fall.
REQ-032 SHALL cover this case: change res to all zeros during byte 3, then assert rst during byte 5 -> bytes 0-4 match the latched value, tx=1 immediately on rst, a later finish restarts at byte 0.

Source files
------------

// File: rtl/ofdm_uart_tx.sv
// ofdm_uart_tx: serialises a latched 96-bit demodulator payload as 12 UART
// bytes (8N1, byte 0 = res[95:88] first, LSB-first per byte).
// Optional feature macro OFDM_UART_CHECKSUM_EN appends a 13th byte holding the
// XOR of the 12 latched payload bytes.
module ofdm_uart_tx #(
    parameter int CLK_FREQ = 27000000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        finish,
    input  logic        success,
    input  logic [95:0] res,
    output logic        clear,
    output logic        tx,
    output logic        busy,
    output logic        tx_done
);

    localparam int unsigned CPB    = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W  = (CPB > 2) ? $clog2(CPB) : 1;
`ifdef OFDM_UART_CHECKSUM_EN
    localparam int unsigned NBYTES = 13;
`else
    localparam int unsigned NBYTES = 12;
`endif

    typedef enum logic [2:0] {IDLE, ACK, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [3:0]         byte_q, byte_d;
    logic [95:0]        pay_q, pay_d;
    logic               succ_q, succ_d;
    logic               tx_d, clear_d, busy_d, done_d;
    logic [7:0]         cur_byte;
    logic [7:0]         fill_byte;

    assign cur_byte = pay_q[95:88];

`ifdef OFDM_UART_CHECKSUM_EN
    logic [7:0] csum_q, csum_d, res_xor;

    // XOR of the 12 incoming payload bytes, captured together with the payload
    always_comb begin
        res_xor = 8'h00;
        for (int k = 0; k < 12; k++) begin
            res_xor = res_xor ^ res[95-8*k -: 8];
        end
    end

    // checksum shifts into the payload buffer behind byte 11
    assign fill_byte = csum_q;

    // checksum register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) csum_q <= 8'h00;
        else     csum_q <= csum_d;
    end
`else
    assign fill_byte = 8'h00;
`endif

    // state, counters, buffers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            pay_q   <= '0;
            succ_q  <= 1'b0;
            tx      <= 1'b1;
            clear   <= 1'b0;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            pay_q   <= pay_d;
            succ_q  <= succ_d;
            tx      <= tx_d;
            clear   <= clear_d;
            busy    <= busy_d;
            tx_done <= done_d;
        end
    end

    // next-state logic; outputs are computed for the upcoming cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        pay_d   = pay_q;
        succ_d  = succ_q;
        tx_d    = 1'b1;
        clear_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef OFDM_UART_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (finish) begin
                    pay_d   = res;
                    succ_d  = success;
`ifdef OFDM_UART_CHECKSUM_EN
                    csum_d  = res_xor;
`endif
                    clear_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (succ_q) begin
                    state_d = START;
                    cnt_d   = CNT_W'(CPB - 1);
                    byte_d  = 4'd0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                busy_d = 1'b1;
                tx_d   = 1'b0;
                if (cnt_q == '0) begin
                    state_d = DATA;
                    cnt_d   = CNT_W'(CPB - 1);
                    bit_d   = 3'd0;
                    tx_d    = cur_byte[0];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                busy_d = 1'b1;
                tx_d   = cur_byte[bit_q];
                if (cnt_q == '0) begin
                    cnt_d = CNT_W'(CPB - 1);
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte[bit_q + 3'd1];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                busy_d = 1'b1;
                tx_d   = 1'b1;
                if (cnt_q == '0) begin
                    if (byte_q == 4'(NBYTES - 1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = START;
                        cnt_d   = CNT_W'(CPB - 1);
                        byte_d  = byte_q + 4'd1;
                        pay_d   = {pay_q[87:0], fill_byte};
                        tx_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ofdm_uart_tx.sv
// Directed bench for ofdm_uart_tx at CLK_FREQ=16, BAUD=1 (16 clocks per bit).
module tb_ofdm_uart_tx;

    localparam int CPB = 16;
`ifdef OFDM_UART_CHECKSUM_EN
    localparam int NB = 13;
`else
    localparam int NB = 12;
`endif
    localparam logic [95:0] RES_A = 96'h55_01_02_03_04_05_06_07_08_09_0A_55;
    localparam logic [95:0] RES_B = 96'hA0_B1_C2_D3_E4_F5_06_17_28_39_4A_5B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        finish = 1'b0;
    logic        success = 1'b0;
    logic [95:0] res = '0;
    logic        clear, tx, busy, tx_done;

    int checks = 0;
    int failures = 0;

    logic [7:0] got [13];
    int done_t, ndone, frame_err;
    logic busy_at_done;

    ofdm_uart_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clk(clk), .rst(rst), .finish(finish), .success(success), .res(res),
        .clear(clear), .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_byte(input logic [95:0] r, input int k);
        logic [7:0] x;
        if (k < 12) return r[95-8*k -: 8];
        x = 8'h00;
        for (int i = 0; i < 12; i++) x = x ^ r[95-8*i -: 8];
        return x;
    endfunction

    // raise finish for one sampled edge; report outputs in cycles N+1 and N+2
    task automatic launch(input logic [95:0] r, input logic s,
                          output logic c1, output logic b1, output logic t1,
                          output logic c2, output logic b2, output logic t2);
        res = r; success = s; finish = 1'b1;
        @(negedge clk);
        c1 = clear; b1 = busy; t1 = tx;
        finish = 1'b0;
        @(negedge clk);
        c2 = clear; b2 = busy; t2 = tx;
    endtask

    // sample tx mid-bit for ncyc cycles starting at the tx-fall cycle (t=0)
    task automatic capture(input int ncyc, input int zero_at);
        int bp, by, b;
        for (int k = 0; k < 13; k++) got[k] = 8'hxx;
        done_t = -1; ndone = 0; frame_err = 0; busy_at_done = 1'bx;
        for (int t = 0; t < ncyc; t++) begin
            if (t % CPB == CPB/2) begin
                bp = t / CPB; by = bp / 10; b = bp % 10;
                if (by < 13) begin
                    if (b == 0 && tx !== 1'b0) frame_err++;
                    else if (b == 9 && tx !== 1'b1) frame_err++;
                    else if (b >= 1 && b <= 8) got[by][b-1] = tx;
                end
            end
            if (tx_done === 1'b1) begin
                ndone++;
                if (done_t < 0) begin done_t = t; busy_at_done = busy; end
            end
            if (t == zero_at) res = '0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, clear, busy, tx_done} !== 4'b1000) begin
                failures++;
                $display("FAIL reset_hold: tx/clear/busy/done=%b required 1000", {tx, clear, busy, tx_done});
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, clear, busy, tx_done} !== 4'b1000) begin
                failures++;
                $display("FAIL reset_release: tx/clear/busy/done=%b required 1000", {tx, clear, busy, tx_done});
            end
        end
    endtask

    task automatic test_frame();
        logic c1, b1, t1, c2, b2, t2;
        launch(RES_A, 1'b1, c1, b1, t1, c2, b2, t2);
        checks++;
        if ({c1, b1, t1} !== 3'b111) begin
            failures++;
            $display("FAIL frame_ack: clear/busy/tx=%b required 111", {c1, b1, t1});
        end
        checks++;
        if ({c2, b2, t2} !== 3'b010) begin
            failures++;
            $display("FAIL frame_start: clear/busy/tx=%b required 010", {c2, b2, t2});
        end
        capture(NB*10*CPB + 1, -1);
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (got[k] !== exp_byte(RES_A, k)) begin
                failures++;
                $display("FAIL frame_byte%0d: got %h required %h", k, got[k], exp_byte(RES_A, k));
            end
        end
        checks++;
        if (frame_err !== 0) begin
            failures++;
            $display("FAIL frame_framing: %0d bad start/stop bits required 0", frame_err);
        end
        checks++;
        if (done_t !== NB*10*CPB || ndone !== 1) begin
            failures++;
            $display("FAIL frame_done: at t=%0d count=%0d required t=%0d count=1", done_t, ndone, NB*10*CPB);
        end
        checks++;
        if (busy_at_done !== 1'b0) begin
            failures++;
            $display("FAIL frame_busy_end: busy=%b at tx_done required 0", busy_at_done);
        end
        checks++;
        if ({tx, busy, tx_done} !== 3'b100) begin
            failures++;
            $display("FAIL frame_after: tx/busy/done=%b required 100", {tx, busy, tx_done});
        end
    endtask

    task automatic test_drop();
        logic c1, b1, t1, c2, b2, t2;
        int bad;
        launch(RES_A, 1'b0, c1, b1, t1, c2, b2, t2);
        checks++;
        if ({c1, b1, t1} !== 3'b111) begin
            failures++;
            $display("FAIL drop_ack: clear/busy/tx=%b required 111", {c1, b1, t1});
        end
        checks++;
        if ({c2, b2, t2} !== 3'b001) begin
            failures++;
            $display("FAIL drop_idle: clear/busy/tx=%b required 001", {c2, b2, t2});
        end
        bad = 0;
        for (int i = 0; i < 3*CPB; i++) begin
            if (tx !== 1'b1 || tx_done !== 1'b0 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL drop_quiet: %0d active cycles required 0", bad);
        end
    endtask

    task automatic test_abort_restart();
        logic c1, b1, t1, c2, b2, t2;
        launch(RES_A, 1'b1, c1, b1, t1, c2, b2, t2);
        checks++;
        if (t2 !== 1'b0) begin
            failures++;
            $display("FAIL abort_start: tx=%b required 0", t2);
        end
        // stop in data bit 1 of byte 5 (0x05 -> bit value 0)
        capture(5*10*CPB + 2*CPB + CPB/2, 3*10*CPB + 5*CPB);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (got[k] !== exp_byte(RES_A, k)) begin
                failures++;
                $display("FAIL abort_byte%0d: got %h required %h", k, got[k], exp_byte(RES_A, k));
            end
        end
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre: tx/busy=%b%b required 01", tx, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({tx, clear, busy, tx_done} !== 4'b1000) begin
            failures++;
            $display("FAIL abort_rst: tx/clear/busy/done=%b required 1000", {tx, clear, busy, tx_done});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        launch(RES_B, 1'b1, c1, b1, t1, c2, b2, t2);
        checks++;
        if ({c1, b1, t1, c2, b2, t2} !== 6'b111010) begin
            failures++;
            $display("FAIL restart_launch: %b required 111010", {c1, b1, t1, c2, b2, t2});
        end
        capture(NB*10*CPB + 1, -1);
        for (int k = 0; k < NB; k++) begin
            checks++;
            if (got[k] !== exp_byte(RES_B, k)) begin
                failures++;
                $display("FAIL restart_byte%0d: got %h required %h", k, got[k], exp_byte(RES_B, k));
            end
        end
        checks++;
        if (done_t !== NB*10*CPB || ndone !== 1 || frame_err !== 0) begin
            failures++;
            $display("FAIL restart_done: t=%0d count=%0d framing=%0d required t=%0d count=1 framing=0",
                     done_t, ndone, frame_err, NB*10*CPB);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_drop();
        test_abort_restart();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
